lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_pkg.sv | 19 +
 rtl/lsu_if.sv | 52 +++++
 rtl/lsu.sv | 205 ++++++++++++++++++++
 tb/tb_lsu.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared constants and state encoding for the load/store unit.
// Memory map bases, access-size codes and FSM states live here.
package lsu_pkg;

    localparam logic [31:0] MEM_DATA_ZERO  = 32'h0001_0000;
    localparam logic [31:0] MMIO_FIFO_ZERO = 32'h0002_0000;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_if.sv
// Bundle of the LSU request/response, data-RAM and FIFO register-bus signals.
// Signal suffixes are written from the LSU's point of view.
interface lsu_if #(
    parameter int DMEM_AW = 10
) ();

    logic                req_valid_i;
    logic                req_write_i;
    logic [1:0]          req_size_i;
    logic                req_unsigned_i;
    logic [31:0]         req_addr_i;
    logic [31:0]         req_wdata_i;
    logic                req_ready_o;

    logic                resp_valid_o;
    logic                resp_err_o;
    logic [31:0]         resp_rdata_o;

    logic                dmem_en_o;
    logic [3:0]          dmem_we_o;
    logic [DMEM_AW-1:0]  dmem_addr_o;
    logic [31:0]         dmem_wdata_o;
    logic [31:0]         dmem_rdata_i;

    logic                fifo_sel_o;
    logic                fifo_read_o;
    logic                fifo_write_o;
    logic [1:0]          fifo_addr_o;
    logic [7:0]          fifo_data_o;
    logic [7:0]          fifo_data_i;

    modport slave (
        input  req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        output req_ready_o,
        output resp_valid_o, resp_err_o, resp_rdata_o,
        output dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        input  dmem_rdata_i,
        output fifo_sel_o, fifo_read_o, fifo_write_o, fifo_addr_o, fifo_data_o,
        input  fifo_data_i
    );

    modport master (
        output req_valid_i, req_write_i, req_size_i, req_unsigned_i, req_addr_i, req_wdata_i,
        input  req_ready_o,
        input  resp_valid_o, resp_err_o, resp_rdata_o,
        input  dmem_en_o, dmem_we_o, dmem_addr_o, dmem_wdata_o,
        output dmem_rdata_i,
        input  fifo_sel_o, fifo_read_o, fifo_write_o, fifo_addr_o, fifo_data_o,
        output fifo_data_i
    );

endinterface

// File: rtl/lsu.sv
// Load/store unit: one outstanding access to the data RAM or the FIFO register bus.
// Strobes are registered so they are high exactly in ACCESS; responses exactly in RESP.
module lsu
    import lsu_pkg::*;
#(
    parameter int DMEM_AW = 10
) (
    input logic  clk_i,
    input logic  rstn_i,
    lsu_if.slave bus
);

    localparam logic [32:0] DMEM_BYTES = 33'd1 << (DMEM_AW + 2);

    lsu_state_e         state_q, state_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic [1:0]         size_q, size_d;
    logic               uns_q, uns_d;
    logic               write_q, write_d;
    logic               fifo_q, fifo_d;

    logic               dmem_en_q, dmem_en_d;
    logic [3:0]         dmem_we_q, dmem_we_d;
    logic [DMEM_AW-1:0] dmem_addr_q, dmem_addr_d;
    logic [31:0]        dmem_wdata_q, dmem_wdata_d;
    logic               fifo_sel_q, fifo_sel_d;
    logic               fifo_read_q, fifo_read_d;
    logic               fifo_write_q, fifo_write_d;
    logic [1:0]         fifo_addr_q, fifo_addr_d;
    logic [7:0]         fifo_data_q, fifo_data_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;

    logic [31:0]        req_off;
    logic               hit_dmem, hit_fifo, req_err;

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SIZE_BYTE: return 4'b0001 << lane;
            SIZE_HALF: return 4'b0011 << lane;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            SIZE_BYTE: return {4{wd[7:0]}};
            SIZE_HALF: return {2{wd[15:0]}};
            default:   return wd;
        endcase
    endfunction

    function automatic logic [31:0] load_extract(input logic [31:0] raw, input logic [1:0] lane,
                                                 input logic [1:0] size, input logic uns);
        logic [31:0] sh;
        sh = raw >> {lane, 3'b000};
        case (size)
            SIZE_BYTE: return uns ? {24'h0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: return uns ? {16'h0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   return sh;
        endcase
    endfunction

    // Addresses below the RAM base wrap to a huge offset, so one compare covers both bounds.
    always_comb begin
        req_off  = bus.req_addr_i - MEM_DATA_ZERO;
        hit_dmem = ({1'b0, req_off} < DMEM_BYTES);
        hit_fifo = (bus.req_addr_i[31:2] == MMIO_FIFO_ZERO[31:2]);
        req_err  = !(hit_dmem || hit_fifo)
                || (bus.req_size_i == 2'd3)
                || ((bus.req_size_i == SIZE_HALF) && bus.req_addr_i[0])
                || ((bus.req_size_i == SIZE_WORD) && (bus.req_addr_i[1:0] != 2'b00))
                || (hit_fifo && (bus.req_size_i != SIZE_BYTE));
    end

    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        uns_d        = uns_q;
        write_d      = write_q;
        fifo_d       = fifo_q;
        dmem_en_d    = 1'b0;
        dmem_we_d    = 4'b0000;
        dmem_addr_d  = '0;
        dmem_wdata_d = 32'h0;
        fifo_sel_d   = 1'b0;
        fifo_read_d  = 1'b0;
        fifo_write_d = 1'b0;
        fifo_addr_d  = 2'b00;
        fifo_data_d  = 8'h00;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = 32'h0;

        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid_i) begin
                    addr_lo_d = bus.req_addr_i[1:0];
                    size_d    = bus.req_size_i;
                    uns_d     = bus.req_unsigned_i;
                    write_d   = bus.req_write_i;
                    fifo_d    = hit_fifo;
                    if (req_err) begin
                        state_d      = ST_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                    end else begin
                        state_d = ST_ACCESS;
                        if (hit_fifo) begin
                            fifo_sel_d   = 1'b1;
                            fifo_read_d  = !bus.req_write_i;
                            fifo_write_d = bus.req_write_i;
                            fifo_addr_d  = bus.req_addr_i[1:0];
                            fifo_data_d  = bus.req_wdata_i[7:0];
                        end else begin
                            dmem_en_d    = 1'b1;
                            dmem_addr_d  = req_off[DMEM_AW+1:2];
                            dmem_we_d    = bus.req_write_i ?
                                           lane_mask(bus.req_size_i, bus.req_addr_i[1:0]) : 4'b0000;
                            dmem_wdata_d = bus.req_write_i ?
                                           lane_data(bus.req_size_i, bus.req_wdata_i) : 32'h0;
                        end
                    end
                end
            end
            ST_ACCESS: begin
                state_d      = write_q ? ST_RESP : ST_WAIT;
                resp_valid_d = write_q;
            end
            ST_WAIT: begin
                // FIFO registers are byte-wide and already LSB-aligned, so no lane shift.
                state_d      = ST_RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = fifo_q ? load_extract({24'h0, bus.fifo_data_i}, 2'b00, size_q, uns_q)
                                      : load_extract(bus.dmem_rdata_i, addr_lo_q, size_q, uns_q);
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= ST_IDLE;
            addr_lo_q    <= 2'b00;
            size_q       <= SIZE_BYTE;
            uns_q        <= 1'b0;
            write_q      <= 1'b0;
            fifo_q       <= 1'b0;
            dmem_en_q    <= 1'b0;
            dmem_we_q    <= 4'b0000;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= 32'h0;
            fifo_sel_q   <= 1'b0;
            fifo_read_q  <= 1'b0;
            fifo_write_q <= 1'b0;
            fifo_addr_q  <= 2'b00;
            fifo_data_q  <= 8'h00;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            write_q      <= write_d;
            fifo_q       <= fifo_d;
            dmem_en_q    <= dmem_en_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            fifo_sel_q   <= fifo_sel_d;
            fifo_read_q  <= fifo_read_d;
            fifo_write_q <= fifo_write_d;
            fifo_addr_q  <= fifo_addr_d;
            fifo_data_q  <= fifo_data_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    // Ready is held low while reset is asserted so every output reads 0 during reset.
    assign bus.req_ready_o  = (state_q == ST_IDLE) && rstn_i;
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_rdata_o = resp_rdata_q;
    assign bus.dmem_en_o    = dmem_en_q;
    assign bus.dmem_we_o    = dmem_we_q;
    assign bus.dmem_addr_o  = dmem_addr_q;
    assign bus.dmem_wdata_o = dmem_wdata_q;
    assign bus.fifo_sel_o   = fifo_sel_q;
    assign bus.fifo_read_o  = fifo_read_q;
    assign bus.fifo_write_o = fifo_write_q;
    assign bus.fifo_addr_o  = fifo_addr_q;
    assign bus.fifo_data_o  = fifo_data_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: byte-lane RAM model and a FIFO register responder
// around the DUT, with hand-computed expectations for each access.
module tb_lsu;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    lsu_if #(.DMEM_AW(10)) bus ();
    lsu #(.DMEM_AW(10)) dut (.clk_i(clk), .rstn_i(rstn), .bus(bus.slave));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_dmem = 0;
    int n_fifo = 0;

    logic [31:0] mem [0:1023];
    logic [31:0] ram_rd = 32'h0;
    logic [7:0]  fifo_rd = 8'h00;

    assign bus.dmem_rdata_i = ram_rd;
    assign bus.fifo_data_i  = fifo_rd;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.dmem_en_o) begin
            n_dmem <= n_dmem + 1;
            for (int b = 0; b < 4; b++)
                if (bus.dmem_we_o[b]) mem[bus.dmem_addr_o][8*b +: 8] <= bus.dmem_wdata_o[8*b +: 8];
            ram_rd <= mem[bus.dmem_addr_o];
        end
        if (bus.fifo_sel_o) begin
            n_fifo <= n_fifo + 1;
            if (bus.fifo_read_o) fifo_rd <= 8'h9C;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Results of the most recent run_op.
    logic [31:0] r_rdata;
    logic        r_err;
    int          r_lat;
    int          acc_cyc;
    logic        a_en, a_fsel, a_frd, a_fwr;
    logic [3:0]  a_we;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata;
    logic [1:0]  a_faddr;
    logic [7:0]  a_fdata;

    task automatic run_op(input logic wr, input logic [1:0] sz, input logic un,
                          input logic [31:0] a, input logic [31:0] wd);
        logic got_rdy;
        got_rdy = 1'b0;
        @(negedge clk);
        bus.req_valid_i    = 1'b1;
        bus.req_write_i    = wr;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = un;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = wd;
        for (int k = 0; k < 10; k++) begin
            if (bus.req_ready_o) begin
                got_rdy = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("ready_wait", {31'h0, got_rdy}, 32'd1);
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        bus.req_valid_i = 1'b0;
        r_lat   = 0;
        r_rdata = 32'h0;
        r_err   = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 1) begin
                a_en = bus.dmem_en_o;   a_we = bus.dmem_we_o;
                a_addr = bus.dmem_addr_o; a_wdata = bus.dmem_wdata_o;
                a_fsel = bus.fifo_sel_o; a_frd = bus.fifo_read_o; a_fwr = bus.fifo_write_o;
                a_faddr = bus.fifo_addr_o; a_fdata = bus.fifo_data_o;
            end
            if (bus.resp_valid_o) begin
                r_lat   = k;
                r_rdata = bus.resp_rdata_o;
                r_err   = bus.resp_err_o;
                break;
            end
        end
        check("resp_seen", {31'h0, r_lat != 0}, 32'd1);
    endtask

    typedef struct { logic wr; logic [1:0] sz; logic [31:0] addr; } err_vec_t;
    err_vec_t   errs [4];
    logic [31:0] tbl [4];
    int bd, bf, seen, prev_acc;
    logic prev_wr;

    initial begin
        bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = 2'd0;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0; bus.req_wdata_i = 32'h0;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'h0, bus.req_ready_o}, 32'd0);
        check("rst_resp_valid", {31'h0, bus.resp_valid_o}, 32'd0);
        check("rst_dmem_en", {31'h0, bus.dmem_en_o}, 32'd0);
        check("rst_fifo_sel", {31'h0, bus.fifo_sel_o}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        check("rel_ready", {31'h0, bus.req_ready_o}, 32'd1);

        // Word store, then read it back.
        run_op(1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'hDEAD_BEEF);
        check("stw_en", {31'h0, a_en}, 32'd1);
        check("stw_we", {28'h0, a_we}, 32'hF);
        check("stw_addr", {22'h0, a_addr}, 32'd1);
        check("stw_wdata", a_wdata, 32'hDEAD_BEEF);
        check("stw_lat", r_lat, 32'd2);
        check("stw_err", {31'h0, r_err}, 32'd0);
        @(negedge clk);
        check("stw_pulse", {31'h0, bus.resp_valid_o}, 32'd0);
        check("stw_ready_after", {31'h0, bus.req_ready_o}, 32'd1);
        run_op(1'b0, 2'd2, 1'b0, 32'h0001_0004, 32'h0);
        check("ldw_we", {28'h0, a_we}, 32'h0);
        check("ldw_data", r_rdata, 32'hDEAD_BEEF);
        check("ldw_lat", r_lat, 32'd3);

        // Byte loads with sign/zero extension from the top lane.
        run_op(1'b1, 2'd2, 1'b0, 32'h0001_0004, 32'h8012_3456);
        run_op(1'b0, 2'd0, 1'b0, 32'h0001_0007, 32'h0);
        check("ldb_s_data", r_rdata, 32'hFFFF_FF80);
        check("ldb_s_lat", r_lat, 32'd3);
        run_op(1'b0, 2'd0, 1'b1, 32'h0001_0007, 32'h0);
        check("ldb_u_data", r_rdata, 32'h0000_0080);

        // Half/byte stores with lane enables, then half loads.
        run_op(1'b1, 2'd1, 1'b0, 32'h0001_0006, 32'hFFFF_1234);
        check("sth_we", {28'h0, a_we}, 32'hC);
        check("sth_wdata", a_wdata, 32'h1234_1234);
        run_op(1'b1, 2'd0, 1'b0, 32'h0001_0005, 32'h0000_00AB);
        check("stb_we", {28'h0, a_we}, 32'h2);
        check("stb_wdata", a_wdata, 32'hABAB_ABAB);
        run_op(1'b0, 2'd1, 1'b0, 32'h0001_0004, 32'h0);
        check("ldh_s_data", r_rdata, 32'hFFFF_AB56);
        run_op(1'b0, 2'd1, 1'b1, 32'h0001_0006, 32'h0);
        check("ldh_u_data", r_rdata, 32'h0000_1234);

        // FIFO register store and load.
        bd = n_dmem; bf = n_fifo;
        run_op(1'b1, 2'd0, 1'b0, 32'h0002_0002, 32'hFFFF_FF41);
        check("fst_sel", {31'h0, a_fsel}, 32'd1);
        check("fst_write", {31'h0, a_fwr}, 32'd1);
        check("fst_read", {31'h0, a_frd}, 32'd0);
        check("fst_addr", {30'h0, a_faddr}, 32'd2);
        check("fst_data", {24'h0, a_fdata}, 32'h41);
        check("fst_no_dmem", n_dmem - bd, 32'd0);
        check("fst_one_strobe", n_fifo - bf, 32'd1);
        check("fst_lat", r_lat, 32'd2);
        run_op(1'b0, 2'd0, 1'b0, 32'h0002_0001, 32'h0);
        check("fld_read", {31'h0, a_frd}, 32'd1);
        check("fld_addr", {30'h0, a_faddr}, 32'd1);
        check("fld_data", r_rdata, 32'hFFFF_FF9C);

        // Error cases: response one cycle after acceptance, no strobes.
        errs[0] = '{1'b0, 2'd1, 32'h0001_0003};
        errs[1] = '{1'b1, 2'd2, 32'h0002_0000};
        errs[2] = '{1'b0, 2'd0, 32'h0003_0000};
        errs[3] = '{1'b0, 2'd3, 32'h0001_0000};
        for (int i = 0; i < 4; i++) begin
            bd = n_dmem; bf = n_fifo;
            run_op(errs[i].wr, errs[i].sz, 1'b0, errs[i].addr, 32'h5555_5555);
            check($sformatf("err%0d_flag", i), {31'h0, r_err}, 32'd1);
            check($sformatf("err%0d_lat", i), r_lat, 32'd1);
            check($sformatf("err%0d_rdata", i), r_rdata, 32'h0);
            check($sformatf("err%0d_strobes", i), (n_dmem - bd) + (n_fifo - bf), 32'd0);
        end

        // Reset asserted while a load sits in WAIT.
        @(negedge clk);
        bus.req_valid_i = 1'b1; bus.req_write_i = 1'b0; bus.req_size_i = 2'd2;
        bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h0001_0004;
        @(posedge clk);
        #1 bus.req_valid_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b0;
        #1;
        check("rstw_ready", {31'h0, bus.req_ready_o}, 32'd0);
        check("rstw_resp", {31'h0, bus.resp_valid_o}, 32'd0);
        check("rstw_outs", {bus.dmem_en_o, bus.dmem_we_o, bus.fifo_sel_o, bus.resp_err_o}, 7'd0);
        @(negedge clk);
        rstn = 1'b1;
        bd = n_dmem; seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (bus.resp_valid_o) seen++;
        end
        check("rstw_no_resp", seen, 32'd0);
        check("rstw_no_strobe", n_dmem - bd, 32'd0);
        check("rstw_ready_after", {31'h0, bus.req_ready_o}, 32'd1);

        // Back-to-back alternating word stores and loads.
        tbl[0] = 32'h0123_4567; tbl[1] = 32'h89AB_CDEF;
        tbl[2] = 32'hFFFF_0000; tbl[3] = 32'h0000_FFFF;
        prev_acc = 0; prev_wr = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic wr;
            wr = (i % 2 == 0);
            run_op(wr, 2'd2, 1'b0, 32'h0001_0100 + 32'(4 * (i / 2)), wr ? tbl[i/2] : 32'h0);
            if (!wr) check($sformatf("b2b%0d_data", i), r_rdata, tbl[i/2]);
            check($sformatf("b2b%0d_lat", i), r_lat, wr ? 32'd2 : 32'd3);
            if (i > 0) check($sformatf("b2b%0d_gap", i), acc_cyc - prev_acc, prev_wr ? 32'd3 : 32'd4);
            prev_acc = acc_cyc;
            prev_wr  = wr;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1);
    end

endmodule
